// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB of 2-bit saturating counters.
// Redirects on EX mispredict or ID jump, honours stall, keeps saturating branch statistics.
module pc_predict_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        ENTRIES  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [1:0]         CTR_INIT = 2'b01,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  input  logic              resolve_pred_taken,
  input  logic [ADDR_W-1:0] resolve_pred_target,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              flush,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic              btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [ADDR_W-1:0] btb_target [ENTRIES];
  logic [1:0]        btb_ctr    [ENTRIES];

  logic [IDX_W-1:0]  f_idx, r_idx;
  logic [TAG_W-1:0]  f_tag, r_tag;
  logic              f_hit, r_hit, mispred;
  logic [ADDR_W-1:0] next_pc;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[ADDR_W-1:IDX_W+2];
  assign r_idx = resolve_pc[IDX_W+1:2];
  assign r_tag = resolve_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads the registered array, so a same-cycle write is seen one cycle later
  assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign pred_taken  = f_hit && btb_ctr[f_idx][1];
  assign pred_target = btb_target[f_idx];
  assign r_hit       = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);

  assign mispred = resolve_valid &&
                   ((resolve_taken != resolve_pred_taken) ||
                    (resolve_taken && (resolve_target != resolve_pred_target)));
  assign flush   = mispred;

  always_comb begin
    next_pc = fetch_pc + ADDR_W'(4);
    if (mispred)
      next_pc = resolve_taken ? align(resolve_target) : resolve_pc + ADDR_W'(4);
    else if (jump_valid)
      next_pc = align(jump_target);
    else if (stall)
      next_pc = fetch_pc;
    else if (pred_taken)
      next_pc = pred_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc         <= RESET_PC;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      fetch_pc <= next_pc;
      if (resolve_valid && (branch_count != '1))
        branch_count <= branch_count + CNT_W'(1);
      if (mispred && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= CTR_INIT;
      end
    end else if (resolve_valid) begin
      if (r_hit) begin
        if (resolve_taken) begin
          if (btb_ctr[r_idx] != 2'b11)
            btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
          btb_target[r_idx] <= align(resolve_target);
        end else if (btb_ctr[r_idx] != 2'b00) begin
          btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
        end
      end else if (resolve_taken) begin
        btb_valid[r_idx]  <= 1'b1;
        btb_tag[r_idx]    <= r_tag;
        btb_target[r_idx] <= align(resolve_target);
        btb_ctr[r_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: a default instance and a small one (4 entries, 2-bit counters)
// share stimulus and are each compared every cycle against a per-config reference model.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, jv, rv, rt, rpt;
  logic [31:0] jt, rpc, rtg, rptg;

  logic [31:0] pc0, pt0_tg, pc1, pt1_tg;
  logic        pt0, fl0, pt1, fl1;
  logic [15:0] bc0, mc0;
  logic [1:0]  bc1, mc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_predict_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_valid(jv), .jump_target(jt),
    .resolve_valid(rv), .resolve_pc(rpc), .resolve_taken(rt), .resolve_target(rtg),
    .resolve_pred_taken(rpt), .resolve_pred_target(rptg),
    .fetch_pc(pc0), .pred_taken(pt0), .pred_target(pt0_tg), .flush(fl0),
    .branch_count(bc0), .mispredict_count(mc0)
  );

  pc_predict_unit #(.ENTRIES(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .jump_valid(jv), .jump_target(jt),
    .resolve_valid(rv), .resolve_pc(rpc), .resolve_taken(rt), .resolve_target(rtg),
    .resolve_pred_taken(rpt), .resolve_pred_target(rptg),
    .fetch_pc(pc1), .pred_taken(pt1), .pred_target(pt1_tg), .flush(fl1),
    .branch_count(bc1), .mispredict_count(mc1)
  );

  // Reference model: one BTB image per configuration (0 = 16 entries, 1 = 4 entries)
  logic        mv   [2][16];
  logic [31:0] mtag [2][16];
  logic [31:0] mtgt [2][16];
  int          mctr [2][16];
  logic [31:0] mpc  [2];
  int unsigned mbc  [2];
  int unsigned mmc  [2];

  function automatic int unsigned ne(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int unsigned cap(input int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mv[k][i] = 1'b0; mtag[k][i] = '0; mtgt[k][i] = '0; mctr[k][i] = 1;
      end
      mpc[k] = '0; mbc[k] = 0; mmc[k] = 0;
    end
  endtask

  function automatic logic m_mis();
    return rv && ((rt != rpt) || (rt && (rtg != rptg)));
  endfunction

  function automatic logic m_pred(input int k, input logic [31:0] pc);
    int unsigned i = (pc / 4) % ne(k);
    return mv[k][i] && (mtag[k][i] == pc / (4 * ne(k))) && (mctr[k][i] >= 2);
  endfunction

  task automatic compare();
    logic [31:0] o_pc, o_tg, o_bc, o_mc;
    logic        o_pt, o_fl;
    for (int k = 0; k < 2; k++) begin
      o_pc = k == 0 ? pc0 : pc1;
      o_tg = k == 0 ? pt0_tg : pt1_tg;
      o_pt = k == 0 ? pt0 : pt1;
      o_fl = k == 0 ? fl0 : fl1;
      o_bc = k == 0 ? 32'(bc0) : 32'(bc1);
      o_mc = k == 0 ? 32'(mc0) : 32'(mc1);
      check("fetch_pc", o_pc, mpc[k]);
      check("pred_taken", 32'(o_pt), 32'(m_pred(k, mpc[k])));
      if (m_pred(k, mpc[k]))
        check("pred_target", o_tg, mtgt[k][(mpc[k] / 4) % ne(k)]);
      check("flush", 32'(o_fl), 32'(m_mis()));
      check("branch_count", o_bc, mbc[k]);
      check("mispredict_count", o_mc, mmc[k]);
    end
  endtask

  task automatic model_step();
    logic        mis = m_mis();
    logic [31:0] nxt;
    int unsigned ri;
    logic        rhit;
    for (int k = 0; k < 2; k++) begin
      if (mis)             nxt = rt ? (rtg & ~32'd3) : rpc + 32'd4;
      else if (jv)         nxt = jt & ~32'd3;
      else if (stall)      nxt = mpc[k];
      else if (m_pred(k, mpc[k])) nxt = mtgt[k][(mpc[k] / 4) % ne(k)];
      else                 nxt = mpc[k] + 32'd4;
      if (rv) begin
        ri   = (rpc / 4) % ne(k);
        rhit = mv[k][ri] && (mtag[k][ri] == rpc / (4 * ne(k)));
        if (rhit && rt) begin
          mctr[k][ri] = (mctr[k][ri] + 1 > 3) ? 3 : mctr[k][ri] + 1;
          mtgt[k][ri] = rtg & ~32'd3;
        end else if (rhit) begin
          mctr[k][ri] = (mctr[k][ri] - 1 < 0) ? 0 : mctr[k][ri] - 1;
        end else if (rt) begin
          mv[k][ri] = 1'b1; mtag[k][ri] = rpc / (4 * ne(k));
          mtgt[k][ri] = rtg & ~32'd3; mctr[k][ri] = 2;
        end
        if (mbc[k] < cap(k)) mbc[k]++;
      end
      if (mis && mmc[k] < cap(k)) mmc[k]++;
      mpc[k] = nxt;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jv = 0; jt = '0; rv = 0; rpc = '0; rt = 0; rtg = '0; rpt = 0; rptg = '0;
  endtask

  task automatic res(input logic [31:0] p, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    idle();
    rv = 1; rpc = p; rt = t; rtg = tg; rpt = pt; rptg = ptg;
  endtask

  task automatic jmp(input logic [31:0] t);
    idle();
    jv = 1; jt = t;
  endtask

  task automatic both(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    check(tag, a, exp);
    check(tag, b, exp);
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    both("rst_pc", pc0, pc1, 32'h0);
    both("rst_pred", 32'(pt0), 32'(pt1), 32'h0);
    both("rst_flush", 32'(fl0), 32'(fl1), 32'h0);
    both("rst_bc", 32'(bc0), 32'(bc1), 32'h0);
    @(posedge clk); #1;
    rst = 1;

    for (int i = 0; i < 4; i++) begin
      idle(); #1;
      both("free_pc", pc0, pc1, 32'(i * 4));
      cyc();
    end

    res(32'h10, 1, 32'h40, 0, 32'h0); #1;
    both("mis_flush", 32'(fl0), 32'(fl1), 32'h1);
    cyc();
    both("mis_redirect", pc0, pc1, 32'h40);
    both("mis_bc", 32'(bc0), 32'(bc1), 32'h1);
    both("mis_mc", 32'(mc0), 32'(mc1), 32'h1);
    jmp(32'h10); cyc();
    idle(); #1;
    both("alloc_pt", 32'(pt0), 32'(pt1), 32'h1);
    both("alloc_tgt", pt0_tg, pt1_tg, 32'h40);
    cyc();

    for (int i = 0; i < 3; i++) begin
      res(32'h10, 1, 32'h40, 1, 32'h40); cyc();
    end
    res(32'h10, 0, 32'h0, 1, 32'h40); cyc();
    both("nt_redirect", pc0, pc1, 32'h14);
    jmp(32'h10); cyc();
    idle(); #1;
    both("ctr2_pt", 32'(pt0), 32'(pt1), 32'h1);
    cyc();
    res(32'h10, 0, 32'h0, 1, 32'h40); cyc();
    jmp(32'h10); cyc();
    idle(); #1;
    both("ctr1_pt", 32'(pt0), 32'(pt1), 32'h0);
    cyc();

    res(32'h20, 0, 32'h0, 1, 32'h60);
    stall = 1; jv = 1; jt = 32'h80; #1;
    both("prio_flush", 32'(fl0), 32'(fl1), 32'h1);
    cyc();
    both("prio_pc", pc0, pc1, 32'h24);

    jmp(32'h8); cyc();
    res(32'h30, 1, 32'h60, 1, 32'h60); stall = 1; cyc();
    both("stall_pc", pc0, pc1, 32'h8);
    for (int i = 0; i < 2; i++) begin
      idle(); stall = 1; cyc();
      both("stall_pc", pc0, pc1, 32'h8);
    end
    check("stall_bc", 32'(bc0), 32'd8);
    check("stall_mc", 32'(mc0), 32'd4);

    res(32'h10, 1, 32'h40, 0, 32'h0); cyc();
    res(32'h50, 1, 32'h70, 0, 32'h0); cyc();
    jmp(32'h10); cyc();
    idle(); #1;
    both("evict_pt", 32'(pt0), 32'(pt1), 32'h0);
    cyc();

    jmp(32'hFFFF_FFFC); cyc();
    idle(); #1;
    both("wrap_pre", pc0, pc1, 32'hFFFF_FFFC);
    cyc();
    both("wrap_pc", pc0, pc1, 32'h0);
    check("sat_bc", 32'(bc1), 32'd3);
    check("sat_mc", 32'(mc1), 32'd3);

    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        rv   = 1;
        rpc  = 32'($urandom_range(0, 31) * 4) | (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
        rt   = 1'($urandom_range(0, 1));
        rtg  = 32'($urandom_range(0, 63) * 4);
        rpt  = ($urandom_range(0, 3) == 0) ? ~rt : rt;
        rptg = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 63) * 4) : rtg;
      end
      if ($urandom_range(0, 9) == 0) begin
        jv = 1; jt = 32'($urandom_range(0, 31) * 4);
      end
      stall = ($urandom_range(0, 4) == 0);
      if (n == 300) begin
        rv = 1; rt = 1; rpt = 0; rpc = 32'h10; rtg = 32'h44;
        #2;
        rst = 0;
        #1;
        both("arst_pc", pc0, pc1, 32'h0);
        both("arst_bc", 32'(bc0), 32'(bc1), 32'h0);
        both("arst_mc", 32'(mc0), 32'(mc1), 32'h0);
        idle();
        @(posedge clk); #1;
        rst = 1;
        model_reset();
      end else begin
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
